kf6845_text_pixel_generator: RTL

Text-mode pixel generator that sits directly downstream of the KF6845 CRT controller. Once per character period it takes MA, RA, DE, HSYNC, VSYNC and CURSOR, and fetches the character/attribute word from video RAM. It then fetches the matching glyph row from font ROM and serialises it into 4-bit IRGBI pixels at dot rate. It applies attribute colours, character blink and cursor blink, and delays the sync and DE signals by one character period so they stay aligned with the pixels.

---
 rtl/kf6845_text_pixel_generator.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/kf6845_text_pixel_generator.sv
// Text-mode pixel generator behind the KF6845 CRTC: per character, fetch {attr,char} then the glyph row, shift IRGBI pixels at dot rate.
// Pixels, sync and DE lag the CRTC by one character period; no backpressure, a fetch still in flight at the next tick sets fetch_overrun.
module kf6845_text_pixel_generator #(
  parameter int VRAM_LATENCY = 2,
  parameter int FONT_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        video_clock_enable,
  input  logic        dot_clock_enable,
  input  logic [13:0] MA,
  input  logic [4:0]  RA,
  input  logic        DE,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        CURSOR,
  input  logic        blink_enable,
  output logic [13:0] vram_address,
  output logic        vram_read,
  input  logic [15:0] vram_data,
  output logic [11:0] font_address,
  output logic        font_read,
  input  logic [7:0]  font_data,
  output logic [3:0]  video_rgbi,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic        fetch_overrun
);

  typedef enum logic [1:0] {IDLE, VRAM_WAIT, FONT_WAIT, READY} state_t;

  state_t     state, state_n;
  logic [2:0] wait_cnt;
  logic [4:0] s1_ra;
  logic       s1_de, s1_cursor, s1_hsync, s1_vsync;
  logic [7:0] glyph, attr;
  logic [7:0] shifter, attr_out;
  logic       cursor_out;
  logic [4:0] frame_cnt;

  logic       tick;
  logic       vram_done, font_done, overrun_tick;
  logic [7:0] load_glyph, load_attr;
  logic       load_cursor;

  assign tick = video_clock_enable;

  function automatic logic [3:0] colour(input logic pix, input logic [7:0] a, input logic cur,
                                        input logic de_v, input logic blink_en, input logic [4:0] cnt);
    logic p;
    p = pix;
    if (blink_en && a[7] && !cnt[4]) p = 1'b0;
    if (cur && cnt[3]) p = 1'b1;
    if (!de_v) return 4'h0;
    return p ? a[3:0] : {1'b0, a[6:4]};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // A tick always restarts the fetch, whatever state it lands in.
  always_comb begin
    state_n      = state;
    vram_done    = 1'b0;
    font_done    = 1'b0;
    overrun_tick = tick && (state != READY);
    case (state)
      VRAM_WAIT: if (!tick && wait_cnt == 3'd0) begin
        vram_done = 1'b1;
        state_n   = FONT_WAIT;
      end
      FONT_WAIT: if (!tick && wait_cnt == 3'd0) begin
        font_done = 1'b1;
        state_n   = READY;
      end
      default: ;
    endcase
    if (tick) state_n = DE ? VRAM_WAIT : READY;
  end

  always_comb begin
    load_glyph  = overrun_tick ? 8'h00 : glyph;
    load_attr   = overrun_tick ? 8'h00 : attr;
    load_cursor = overrun_tick ? 1'b0  : s1_cursor;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt      <= 3'd0;
      s1_ra         <= 5'd0;
      s1_de         <= 1'b0;
      s1_cursor     <= 1'b0;
      s1_hsync      <= 1'b0;
      s1_vsync      <= 1'b0;
      glyph         <= 8'h00;
      attr          <= 8'h00;
      shifter       <= 8'h00;
      attr_out      <= 8'h00;
      cursor_out    <= 1'b0;
      frame_cnt     <= 5'd0;
      vram_address  <= 14'd0;
      vram_read     <= 1'b0;
      font_address  <= 12'd0;
      font_read     <= 1'b0;
      video_rgbi    <= 4'h0;
      video_hsync   <= 1'b0;
      video_vsync   <= 1'b0;
      video_de      <= 1'b0;
      fetch_overrun <= 1'b0;
    end else begin
      vram_read <= 1'b0;
      font_read <= 1'b0;

      if (tick) begin
        s1_ra     <= RA;
        s1_de     <= DE;
        s1_cursor <= CURSOR;
        s1_hsync  <= HSYNC;
        s1_vsync  <= VSYNC;
        if (VSYNC && !s1_vsync) frame_cnt <= frame_cnt + 5'd1;

        attr_out    <= load_attr;
        cursor_out  <= load_cursor;
        video_hsync <= s1_hsync;
        video_vsync <= s1_vsync;
        video_de    <= s1_de;
        if (overrun_tick) fetch_overrun <= 1'b1;

        glyph <= 8'h00;
        attr  <= 8'h00;
        if (DE) begin
          vram_address <= MA;
          vram_read    <= 1'b1;
          wait_cnt     <= 3'(VRAM_LATENCY);
        end
      end else if (vram_done) begin
        // Font strobe goes out on the same edge the VRAM word lands.
        attr         <= vram_data[15:8];
        font_address <= {vram_data[7:0], s1_ra[3:0]};
        font_read    <= 1'b1;
        wait_cnt     <= 3'(FONT_LATENCY);
      end else if (font_done) begin
        glyph <= font_data;
      end else if (wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (tick) begin
        shifter    <= load_glyph;
        video_rgbi <= colour(load_glyph[7], load_attr, load_cursor, s1_de, blink_enable, frame_cnt);
      end else if (dot_clock_enable) begin
        shifter    <= {shifter[6:0], 1'b0};
        video_rgbi <= colour(shifter[6], attr_out, cursor_out, video_de, blink_enable, frame_cnt);
      end
    end
  end

endmodule
